cymometer_mc: RTL and testbench

//  Multi-channel equal-precision frequency meter core, single sys_clk domain. Measures CH_NUM

---
 rtl/cymometer_mc.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_cymometer_mc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cymometer_mc.sv
// cymometer_mc: multi-channel equal-precision frequency meter, one shared soft gate and one
// time-shared restoring divider. Define CYMO_PERIOD_EN to add the `mode` input (mean-period output).
module cymometer_mc #(
   parameter int CH_NUM       = 4,
   parameter int CNT_W        = 30,
   parameter int CLK_FS_FREQ  = 100_000_000,
   parameter int FREQ_W       = 27,
   parameter int RES_W        = 32,
`ifdef CYMO_PERIOD_EN
   parameter int PERIOD_SCALE = 10,
`endif
   parameter int GATE_W       = 30
) (
   input  logic                                           sys_clk,
   input  logic                                           sys_rst,
   input  logic                                           start,
   input  logic [GATE_W-1:0]                              gate_cycles,
   input  logic [CH_NUM-1:0]                              clk_fx,
`ifdef CYMO_PERIOD_EN
   input  logic                                           mode,
`endif
   output logic                                           busy,
   output logic                                           res_valid,
   input  logic                                           res_ready,
   output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] res_ch,
   output logic [RES_W-1:0]                               res_data,
   output logic                                           res_ovf
);
   localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int DIVD_W = CNT_W + FREQ_W;
   localparam int STEP_W = $clog2(DIVD_W + 1);
   localparam logic [DIVD_W-1:0] FS_K = DIVD_W'(CLK_FS_FREQ);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GATE  = 3'd1;
   localparam logic [2:0] S_CLOSE = 3'd2;
   localparam logic [2:0] S_DIV   = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Returns {ovf, value}: quotients wider than RES_W clamp to all-ones.
   function automatic logic [RES_W:0] sat_res(input logic [DIVD_W-1:0] q);
      if (|q[DIVD_W-1:RES_W]) return {1'b1, {RES_W{1'b1}}};
      return {1'b0, q[RES_W-1:0]};
   endfunction

   logic [2:0]        state_q, state_d;
   logic              busy_q, busy_d;
   logic [GATE_W-1:0] gate_len_q, gate_len_d;
   logic [GATE_W-1:0] tcnt_q, tcnt_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [DIVD_W-1:0] quo_q, quo_d;
   logic [CNT_W-1:0]  dvs_q, dvs_d;
   logic              res_valid_q, res_valid_d;
   logic [CH_W-1:0]   res_ch_q, res_ch_d;
   logic [RES_W-1:0]  res_data_q, res_data_d;
   logic              res_ovf_q, res_ovf_d;
`ifdef CYMO_PERIOD_EN
   logic              mode_q, mode_d;
`endif

   logic [CH_NUM-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
   logic [CH_NUM-1:0] open_q, open_d, ovf_q, ovf_d;
   logic [CNT_W-1:0]  nx_q [CH_NUM];
   logic [CNT_W-1:0]  nx_d [CH_NUM];
   logic [CNT_W-1:0]  ns_q [CH_NUM];
   logic [CNT_W-1:0]  ns_d [CH_NUM];

   logic [CH_NUM-1:0] edge_w;
   logic              accept, gate_on, close_on, timeout;

   assign edge_w   = s1_q & ~s2_q;
   assign accept   = (state_q == S_IDLE) && start;
   assign gate_on  = (state_q == S_GATE);
   assign close_on = (state_q == S_CLOSE);
   assign timeout  = close_on && (|open_q) && (tcnt_q == gate_len_q - 1'b1);

   // Per-channel real gate: opens on an edge under the soft gate, closes on the first edge after it.
   always_comb begin
      s0_d   = clk_fx;
      s1_d   = s0_q;
      s2_d   = s1_q;
      open_d = open_q;
      ovf_d  = ovf_q;
      for (int i = 0; i < CH_NUM; i++) begin
         nx_d[i] = nx_q[i];
         ns_d[i] = ns_q[i];
         if (accept) begin
            open_d[i] = 1'b0;
            ovf_d[i]  = 1'b0;
            nx_d[i]   = '0;
            ns_d[i]   = '0;
         end else if (gate_on || close_on) begin
            if (open_q[i]) begin
               ns_d[i] = sat_inc(ns_q[i]);
               if (edge_w[i]) begin
                  nx_d[i] = sat_inc(nx_q[i]);
                  if (close_on) open_d[i] = 1'b0;
               end
               if ((&ns_d[i]) || (&nx_d[i])) ovf_d[i] = 1'b1;
               if (timeout && open_d[i]) begin
                  open_d[i] = 1'b0;
                  ovf_d[i]  = 1'b1;
               end
            end else if (gate_on && edge_w[i]) begin
               open_d[i] = 1'b1;
            end
         end
      end
   end

   logic [CNT_W-1:0]  nx_sel, ns_sel, dvs_ld;
   logic [DIVD_W-1:0] dvd_ld, quo_it;
   logic [CNT_W:0]    rem_sh;
   logic              sub_ok, skip;
   logic [RES_W:0]    res_w;

   always_comb begin
      nx_sel = nx_q[ch_q];
      ns_sel = ns_q[ch_q];
      dvd_ld = DIVD_W'(nx_sel) * FS_K;
      dvs_ld = ns_sel;
`ifdef CYMO_PERIOD_EN
      if (mode_q) begin
         dvd_ld = DIVD_W'(ns_sel) * DIVD_W'(PERIOD_SCALE);
         dvs_ld = nx_sel;
      end
`endif
      skip   = ovf_q[ch_q] || (dvs_ld == '0);
      rem_sh = {rem_q, quo_q[DIVD_W-1]};
      sub_ok = (rem_sh >= {1'b0, dvs_q});
      quo_it = {quo_q[DIVD_W-2:0], sub_ok};
      res_w  = sat_res(quo_it);
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      gate_len_d  = gate_len_q;
      tcnt_d      = tcnt_q;
      ch_d        = ch_q;
      step_d      = step_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      res_valid_d = res_valid_q;
      res_ch_d    = res_ch_q;
      res_data_d  = res_data_q;
      res_ovf_d   = res_ovf_q;
`ifdef CYMO_PERIOD_EN
      mode_d      = mode_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               gate_len_d = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
               tcnt_d     = '0;
               busy_d     = 1'b1;
               state_d    = S_GATE;
`ifdef CYMO_PERIOD_EN
               mode_d     = mode;
`endif
            end
         end
         S_GATE: begin
            if (tcnt_q == gate_len_q - 1'b1) begin
               tcnt_d  = '0;
               state_d = S_CLOSE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_CLOSE: begin
            if (!(|open_q) || timeout) begin
               ch_d    = '0;
               step_d  = '0;
               state_d = S_DIV;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_DIV: begin
            // Step 0 loads operands; steps 1..DIVD_W each retire one quotient bit, MSB first.
            if (step_q == '0) begin
               if (skip) begin
                  res_ch_d    = ch_q;
                  res_data_d  = '0;
                  res_ovf_d   = 1'b1;
                  res_valid_d = 1'b1;
                  state_d     = S_OUT;
               end else begin
                  rem_d  = '0;
                  quo_d  = dvd_ld;
                  dvs_d  = dvs_ld;
                  step_d = STEP_W'(1);
               end
            end else begin
               rem_d = sub_ok ? CNT_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[CNT_W-1:0];
               quo_d = quo_it;
               if (step_q == STEP_W'(DIVD_W)) begin
                  res_ch_d    = ch_q;
                  res_ovf_d   = res_w[RES_W];
                  res_data_d  = res_w[RES_W-1:0];
                  res_valid_d = 1'b1;
                  state_d     = S_OUT;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         S_OUT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               if (ch_q == CH_W'(CH_NUM - 1)) begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  ch_d    = ch_q + 1'b1;
                  step_d  = '0;
                  state_d = S_DIV;
               end
            end
         end
         default: begin
            busy_d      = 1'b0;
            res_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         gate_len_q  <= '0;
         tcnt_q      <= '0;
         ch_q        <= '0;
         step_q      <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         res_valid_q <= 1'b0;
         res_ch_q    <= '0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
`ifdef CYMO_PERIOD_EN
         mode_q      <= 1'b0;
`endif
         s0_q        <= '0;
         s1_q        <= '0;
         s2_q        <= '0;
         open_q      <= '0;
         ovf_q       <= '0;
         nx_q        <= '{default: '0};
         ns_q        <= '{default: '0};
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         gate_len_q  <= gate_len_d;
         tcnt_q      <= tcnt_d;
         ch_q        <= ch_d;
         step_q      <= step_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         res_valid_q <= res_valid_d;
         res_ch_q    <= res_ch_d;
         res_data_q  <= res_data_d;
         res_ovf_q   <= res_ovf_d;
`ifdef CYMO_PERIOD_EN
         mode_q      <= mode_d;
`endif
         s0_q        <= s0_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         open_q      <= open_d;
         ovf_q       <= ovf_d;
         nx_q        <= nx_d;
         ns_q        <= ns_d;
      end
   end

   assign busy      = busy_q;
   assign res_valid = res_valid_q;
   assign res_ch    = res_ch_q;
   assign res_data  = res_data_q;
   assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_cymometer_mc.sv
// Directed bench for cymometer_mc: measurement rounds against known input frequencies.
// Time unit: sys_clk period is 10 units (100 MHz); fx edges sit off the clock edges.
module tb_cymometer_mc;
   localparam int GATE_W = 30;
   localparam int RES_W  = 32;

   typedef struct {
      int ch;
      int data;
      int tol;
      bit ovf;
   } vec_t;

   logic              sys_clk     = 1'b0;
   logic              sys_rst     = 1'b1;
   logic              start       = 1'b0;
   logic [GATE_W-1:0] gate_cycles = '0;
   logic              res_ready   = 1'b0;
   logic              fx0 = 1'b0;
   logic              fx1 = 1'b0;
   logic              fx2 = 1'b0;
   logic [3:0]        clk_fx;
   logic              busy, res_valid, res_ovf;
   logic [1:0]        res_ch;
   logic [RES_W-1:0]  res_data;
`ifdef CYMO_PERIOD_EN
   logic              mode = 1'b0;
   vec_t              rp[4];
`endif

   int hp0 = 500;
   int hp1 = 200;
   int hp2 = 15150;
   bit en0 = 1'b1;
   int errors = 0;
   int checks = 0;
   vec_t r1[4], r2[4], r3[4];

   assign clk_fx = {1'b0, fx2, fx1, fx0};

   cymometer_mc dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .start       (start),
      .gate_cycles (gate_cycles),
      .clk_fx      (clk_fx),
`ifdef CYMO_PERIOD_EN
      .mode        (mode),
`endif
      .busy        (busy),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_ch      (res_ch),
      .res_data    (res_data),
      .res_ovf     (res_ovf)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #1;
      forever begin
         #hp0;
         if (en0) fx0 = ~fx0;
      end
   end

   initial begin
      #1;
      forever begin
         #hp1;
         fx1 = ~fx1;
      end
   end

   initial begin
      #1;
      forever begin
         #hp2;
         fx2 = ~fx2;
      end
   end

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   task automatic check(input string name, input longint act, input longint exp, input longint tol);
      checks++;
      if (act > exp + tol || act < exp - tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!res_valid && n < 20000) begin
         @(negedge sys_clk);
         n++;
      end
      if (!res_valid) begin
         checks++;
         errors++;
         $display("FAIL %s: res_valid timeout, got 0, expected 1", name);
         finish_run();
      end
   endtask

   task automatic pulse_start(input int gate);
      gate_cycles = GATE_W'(gate);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic take(input string tag, input vec_t v);
      check({tag, "_ch"}, longint'(res_ch), longint'(v.ch), 0);
      check({tag, "_data"}, longint'(res_data), longint'(v.data), longint'(v.tol));
      check({tag, "_ovf"}, longint'(res_ovf), longint'(v.ovf), 0);
      res_ready = 1'b1;
      @(negedge sys_clk);
      res_ready = 1'b0;
      check({tag, "_vld_low"}, longint'(res_valid), 0, 0);
   endtask

   task automatic run_round(input string tag, input vec_t v[4]);
      for (int i = 0; i < 4; i++) begin
         wait_valid($sformatf("%s_ch%0d_wait", tag, i));
         take($sformatf("%s_ch%0d", tag, i), v[i]);
      end
      check({tag, "_busy_end"}, longint'(busy), 0, 0);
   endtask

   initial begin
      // ch2 runs at 1e8/3030 Hz in round 1 (33_003 Hz), then 10 MHz from round 2 on.
      r1 = '{'{0, 1000000, 0, 1'b0}, '{1, 2500000, 0, 1'b0}, '{2, 33000, 4, 1'b0}, '{3, 0, 0, 1'b1}};
      r2 = '{'{0, 1000000, 0, 1'b0}, '{1, 2500000, 0, 1'b0}, '{2, 10000000, 0, 1'b0}, '{3, 0, 0, 1'b1}};
      r3 = '{'{0, 0, 0, 1'b1}, '{1, 2500000, 0, 1'b0}, '{2, 10000000, 0, 1'b0}, '{3, 0, 0, 1'b1}};
`ifdef CYMO_PERIOD_EN
      rp = '{'{0, 1000, 0, 1'b0}, '{1, 400, 0, 1'b0}, '{2, 100, 0, 1'b0}, '{3, 0, 0, 1'b1}};
`endif

      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      check("rst_busy", longint'(busy), 0, 0);
      check("rst_valid", longint'(res_valid), 0, 0);
      check("rst_ch", longint'(res_ch), 0, 0);
      check("rst_data", longint'(res_data), 0, 0);
      check("rst_ovf", longint'(res_ovf), 0, 0);

      // Round 1: nominal frequencies, stalled consumer, start pulses while busy.
      pulse_start(10000);
      gate_cycles = GATE_W'(5);
      check("r1_busy_start", longint'(busy), 1, 0);
      repeat (100) @(negedge sys_clk);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_valid($sformatf("r1_ch%0d_wait", i));
         if (i == 0) begin
            repeat (50) @(negedge sys_clk);
            check("r1_stall_vld", longint'(res_valid), 1, 0);
         end
         take($sformatf("r1_ch%0d", i), r1[i]);
         if (i == 0) begin
            start = 1'b1;
            @(negedge sys_clk);
            start = 1'b0;
         end
      end
      check("r1_busy_end", longint'(busy), 0, 0);
      repeat (200) @(negedge sys_clk);
      check("r1_no_rerun_busy", longint'(busy), 0, 0);
      check("r1_no_rerun_vld", longint'(res_valid), 0, 0);

      // Round 2: reset in the middle of ch1's division, then a fresh round.
      hp2 = 50;
      repeat (2000) @(negedge sys_clk);
      pulse_start(2000);
      wait_valid("r2a_ch0_wait");
      take("r2a_ch0", r2[0]);
      repeat (20) @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      check("r2_rst_busy", longint'(busy), 0, 0);
      check("r2_rst_vld", longint'(res_valid), 0, 0);
      repeat (100) @(negedge sys_clk);
      check("r2_rst_quiet", longint'(res_valid), 0, 0);
      pulse_start(2000);
      run_round("r2", r2);

      // Round 3: ch0 stops high mid-gate, so its real gate never closes.
      repeat (20) @(negedge sys_clk);
      pulse_start(2000);
      repeat (500) @(negedge sys_clk);
      @(posedge fx0);
      en0 = 1'b0;
      run_round("r3", r3);
      en0 = 1'b1;

`ifdef CYMO_PERIOD_EN
      repeat (200) @(negedge sys_clk);
      mode = 1'b1;
      pulse_start(2000);
      mode = 1'b0;
      run_round("rp", rp);
`endif

      finish_run();
   end

endmodule
